// File: rtl/w_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | w_serializer: parallel word to MSB-first serial stream on w, with a        |
// | one-entry holding buffer and optional inter-word gap.                      |
// | Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module w_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             w,
  output logic             w_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int c_CW = $clog2(WIDTH);
  localparam int c_GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [c_CW-1:0] c_LAST_BIT = c_CW'(WIDTH - 1);
  localparam logic [c_GW-1:0] c_LAST_GAP = c_GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef SER_PARITY_EN
    ST_PARITY = 2'd3,
`endif
    ST_GAP    = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_buf, r_shreg, w_shreg_nxt;
  logic             r_buf_full, w_buf_full_nxt;
  logic [c_CW-1:0]  r_cnt, w_cnt_nxt;
  logic [c_GW-1:0]  r_gcnt, w_gcnt_nxt;
  logic             r_w, r_w_valid, r_word_done, r_busy;
  logic             w_bit_nxt, w_valid_nxt, w_done_nxt;
  logic             w_take, w_load, w_frame_end, w_exit;
`ifdef SER_PARITY_EN
  logic             r_par;
`endif

  assign w_take         = in_valid & ~r_buf_full;
  assign w_buf_full_nxt = w_take | (r_buf_full & ~w_load);

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_gcnt_nxt  = r_gcnt;
    w_bit_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_frame_end = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_buf_full) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_bit_nxt   = r_shreg[WIDTH-1];
        w_valid_nxt = 1'b1;
        w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
        w_cnt_nxt   = r_cnt + c_CW'(1);
        if (r_cnt == c_LAST_BIT) begin
`ifdef SER_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_done_nxt  = 1'b1;
          w_frame_end = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PARITY: begin
        w_bit_nxt   = r_par;
        w_valid_nxt = 1'b1;
        w_done_nxt  = 1'b1;
        w_frame_end = 1'b1;
      end
`endif
      ST_GAP: begin
        w_gcnt_nxt = r_gcnt + c_GW'(1);
        if (r_gcnt == c_LAST_GAP) w_exit = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_frame_end) begin
      if (GAP > 0) begin
        w_state_nxt = ST_GAP;
        w_gcnt_nxt  = '0;
      end else begin
        w_exit = 1'b1;
      end
    end

    // Frame exit: chain straight into the buffered word so back-to-back has no bubble
    if (w_exit) begin
      if (r_buf_full) begin
        w_load      = 1'b1;
        w_state_nxt = ST_SHIFT;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end

    if (w_load) begin
      w_shreg_nxt = r_buf;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_gcnt      <= '0;
      r_w         <= 1'b0;
      r_w_valid   <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SER_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_buf_full  <= w_buf_full_nxt;
      if (w_take) r_buf <= in_data;
      r_shreg     <= w_shreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gcnt      <= w_gcnt_nxt;
      r_w         <= w_bit_nxt;
      r_w_valid   <= w_valid_nxt;
      r_word_done <= w_done_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE) || w_buf_full_nxt;
`ifdef SER_PARITY_EN
      if (w_load) r_par <= ^r_buf;
`endif
    end
  end

  assign in_ready  = ~r_buf_full;
  assign w         = r_w;
  assign w_valid   = r_w_valid;
  assign word_done = r_word_done;
  assign busy      = r_busy;

endmodule
`default_nettype wire
